// File: rtl/dual_port_ram_pipe_if.sv
// -----------------------------------------------------------------------------
// dual_port_ram_pipe_if
//   Bus bundle for the simple dual-port RAM: write port, read request port and
//   the returned-read signals.
//   master : drives write/read requests, receives data_out/rd_valid/collision
//   slave  : the RAM side
// Signals
//   write, wr_address, data_in, wr_byte_en  write request (one word, byte lanes)
//   read, rd_address                        read request
//   data_out, rd_valid, collision           returned read data and qualifiers
// -----------------------------------------------------------------------------
interface dual_port_ram_pipe_if #(
   parameter int DATA_WIDTH = 64,
   parameter int ADDR_WIDTH = 12
);
   logic                    write;
   logic [ADDR_WIDTH-1:0]   wr_address;
   logic [DATA_WIDTH-1:0]   data_in;
   logic [DATA_WIDTH/8-1:0] wr_byte_en;
   logic                    read;
   logic [ADDR_WIDTH-1:0]   rd_address;
   logic [DATA_WIDTH-1:0]   data_out;
   logic                    rd_valid;
   logic                    collision;

   modport master (
      output write, wr_address, data_in, wr_byte_en, read, rd_address,
      input  data_out, rd_valid, collision
   );

   modport slave (
      input  write, wr_address, data_in, wr_byte_en, read, rd_address,
      output data_out, rd_valid, collision
   );
endinterface

// File: rtl/dual_port_ram_pipe.sv
// -----------------------------------------------------------------------------
// dual_port_ram_pipe
//   Simple dual-port RAM (one write port, one read port, one clock) with
//   per-byte write enables, a READ_LATENCY-deep read pipeline with a valid
//   strobe, and a selectable same-address read-during-write policy.
// Ports
//   i_clk  rising-edge clock
//   i_rst  synchronous active-high reset (clears read pipe, not the array)
//   bus    dual_port_ram_pipe_if.slave : write/read requests and read results
// -----------------------------------------------------------------------------
module dual_port_ram_pipe #(
   parameter int DATA_WIDTH   = 64,
   parameter int ADDR_WIDTH   = 12,
   parameter int READ_LATENCY = 2,
   parameter int WRITE_FIRST  = 0
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   dual_port_ram_pipe_if.slave  bus
);
   localparam int NUM_BYTES = DATA_WIDTH / 8;
   localparam int DEPTH     = 1 << ADDR_WIDTH;

   if (DATA_WIDTH % 8 != 0) begin : g_bad_width
      $fatal(1, "dual_port_ram_pipe: DATA_WIDTH must be a multiple of 8");
   end
   if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
      $fatal(1, "dual_port_ram_pipe: READ_LATENCY must be 1..4");
   end

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];

   // Stage 0: raw array output plus what is needed to resolve a collision
   logic                  r_s0_valid;
   logic                  r_s0_col;
   logic [DATA_WIDTH-1:0] r_s0_data;
   logic [DATA_WIDTH-1:0] r_s0_wdata;
   logic [NUM_BYTES-1:0]  r_s0_be;
   logic                  w_collide;
   logic [DATA_WIDTH-1:0] w_s0_data;

   assign w_collide = bus.read && bus.write &&
                      (bus.rd_address == bus.wr_address) && (|bus.wr_byte_en);

   // Array: no reset so it maps onto block RAM. The read register samples the
   // pre-write contents (non-blocking update), which is the read-first word.
   always_ff @(posedge i_clk) begin
      if (!i_rst && bus.write) begin
         for (int b = 0; b < NUM_BYTES; b++) begin
            if (bus.wr_byte_en[b]) begin
               r_mem[bus.wr_address][8*b +: 8] <= bus.data_in[8*b +: 8];
            end
         end
      end
      if (bus.read) begin
         r_s0_data <= r_mem[bus.rd_address];
      end
   end

   // Colliding write payload, captured only when it can matter
   always_ff @(posedge i_clk) begin
      if (w_collide) begin
         r_s0_wdata <= bus.data_in;
         r_s0_be    <= bus.wr_byte_en;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_s0_valid <= 1'b0;
         r_s0_col   <= 1'b0;
      end else begin
         r_s0_valid <= bus.read;
         r_s0_col   <= w_collide;
      end
   end

   // Write-first merge: replace only the lanes the colliding write enabled
   genvar gi;
   for (gi = 0; gi < NUM_BYTES; gi++) begin : g_merge
      assign w_s0_data[8*gi +: 8] =
         ((WRITE_FIRST != 0) && r_s0_col && r_s0_be[gi]) ? r_s0_wdata[8*gi +: 8]
                                                         : r_s0_data[8*gi +: 8];
   end

   // Delay stages 1..READ_LATENCY; the last one is the output register, which
   // only loads on a returned read so data_out holds between results.
   for (gi = 1; gi <= READ_LATENCY; gi++) begin : g_stage
      logic                  r_v;
      logic                  r_c;
      logic [DATA_WIDTH-1:0] r_d;
      logic                  w_v_in;
      logic                  w_c_in;
      logic [DATA_WIDTH-1:0] w_d_in;

      if (gi == 1) begin : g_first
         assign w_v_in = r_s0_valid;
         assign w_c_in = r_s0_col;
         assign w_d_in = w_s0_data;
      end else begin : g_next
         assign w_v_in = g_stage[gi-1].r_v;
         assign w_c_in = g_stage[gi-1].r_c;
         assign w_d_in = g_stage[gi-1].r_d;
      end

      if (gi == READ_LATENCY) begin : g_out
         always_ff @(posedge i_clk) begin
            if (i_rst) begin
               r_v <= 1'b0;
               r_c <= 1'b0;
               r_d <= '0;
            end else begin
               r_v <= w_v_in;
               r_c <= w_c_in & w_v_in;
               if (w_v_in) begin
                  r_d <= w_d_in;
               end
            end
         end
      end else begin : g_mid
         always_ff @(posedge i_clk) begin
            if (i_rst) begin
               r_v <= 1'b0;
               r_c <= 1'b0;
            end else begin
               r_v <= w_v_in;
               r_c <= w_c_in & w_v_in;
            end
         end
         always_ff @(posedge i_clk) begin
            r_d <= w_d_in;
         end
      end
   end

   assign bus.data_out  = g_stage[READ_LATENCY].r_d;
   assign bus.rd_valid  = g_stage[READ_LATENCY].r_v;
   assign bus.collision = g_stage[READ_LATENCY].r_c;
endmodule

// File: tb/tb_dual_port_ram_pipe.sv
// -----------------------------------------------------------------------------
// tb_dual_port_ram_pipe
//   Three RAM instances share one stimulus stream:
//     dut 0 : READ_LATENCY=2, WRITE_FIRST=0
//     dut 1 : READ_LATENCY=1, WRITE_FIRST=1
//     dut 2 : READ_LATENCY=4, WRITE_FIRST=0
//   Each read pushes its hand-written expected word into a per-instance queue
//   tagged with the cycle it must return on; a negedge monitor compares every
//   cycle's rd_valid / data_out / collision against that queue.
// -----------------------------------------------------------------------------
module tb_dual_port_ram_pipe;
   localparam int DW = 64;
   localparam int AW = 12;
   localparam int NB = DW / 8;
   localparam int LAT [3] = '{2, 1, 4};
   localparam int WF  [3] = '{0, 1, 0};

   typedef struct {
      int            due;
      logic [DW-1:0] data;
      logic          col;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          tb_write = 1'b0;
   logic [AW-1:0] tb_wr_address = '0;
   logic [DW-1:0] tb_data_in = '0;
   logic [NB-1:0] tb_wr_byte_en = '0;
   logic          tb_read = 1'b0;
   logic [AW-1:0] tb_rd_address = '0;

   int   n_checks = 0;
   int   n_fail   = 0;
   int   pcnt     = 0;
   logic rst_s    = 1'b1;
   logic mon_en   = 1'b0;

   exp_t          q [3][$];
   logic [DW-1:0] last_dout [3];
   logic [DW-1:0] dout [3];
   logic          vld  [3];
   logic          coll [3];

   always #5 clk = ~clk;

   always @(posedge clk) begin
      pcnt  <= pcnt + 1;
      rst_s <= rst;
   end

   dual_port_ram_pipe_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus0 ();
   dual_port_ram_pipe_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus1 ();
   dual_port_ram_pipe_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus2 ();

   assign bus0.write = tb_write;      assign bus1.write = tb_write;      assign bus2.write = tb_write;
   assign bus0.wr_address = tb_wr_address;
   assign bus1.wr_address = tb_wr_address;
   assign bus2.wr_address = tb_wr_address;
   assign bus0.data_in = tb_data_in;  assign bus1.data_in = tb_data_in;  assign bus2.data_in = tb_data_in;
   assign bus0.wr_byte_en = tb_wr_byte_en;
   assign bus1.wr_byte_en = tb_wr_byte_en;
   assign bus2.wr_byte_en = tb_wr_byte_en;
   assign bus0.read = tb_read;        assign bus1.read = tb_read;        assign bus2.read = tb_read;
   assign bus0.rd_address = tb_rd_address;
   assign bus1.rd_address = tb_rd_address;
   assign bus2.rd_address = tb_rd_address;

   assign dout[0] = bus0.data_out;  assign vld[0] = bus0.rd_valid;  assign coll[0] = bus0.collision;
   assign dout[1] = bus1.data_out;  assign vld[1] = bus1.rd_valid;  assign coll[1] = bus1.collision;
   assign dout[2] = bus2.data_out;  assign vld[2] = bus2.rd_valid;  assign coll[2] = bus2.collision;

   dual_port_ram_pipe #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(2), .WRITE_FIRST(0))
      dut0 (.i_clk(clk), .i_rst(rst), .bus(bus0));
   dual_port_ram_pipe #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(1), .WRITE_FIRST(1))
      dut1 (.i_clk(clk), .i_rst(rst), .bus(bus1));
   dual_port_ram_pipe #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(4), .WRITE_FIRST(0))
      dut2 (.i_clk(clk), .i_rst(rst), .bus(bus2));

   task automatic check(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // One clock of stimulus. Called just after a posedge; the request is
   // accepted on the next posedge (count pcnt+1) and returns LAT cycles later.
   task automatic step(input logic w, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic [NB-1:0] be, input logic r, input logic [AW-1:0] ra,
                       input logic [DW-1:0] e_old, input logic [DW-1:0] e_new, input logic c);
      tb_write      = w;
      tb_wr_address = wa;
      tb_data_in    = wd;
      tb_wr_byte_en = be;
      tb_read       = r;
      tb_rd_address = ra;
      if (r) begin
         for (int d = 0; d < 3; d++) begin
            q[d].push_back('{due: pcnt + 1 + LAT[d], data: (WF[d] != 0) ? e_new : e_old, col: c});
         end
         $display("txn t=%0t rd @%03h exp_wf0=%h exp_wf1=%h col=%0d wr=%0d @%03h be=%02h",
                  $time, ra, e_old, e_new, c, w, wa, be);
      end else if (w) begin
         $display("txn t=%0t wr @%03h data=%h be=%02h", $time, wa, wd, be);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NB-1:0] be);
      step(1'b1, a, d, be, 1'b0, '0, '0, '0, 1'b0);
   endtask

   task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] e);
      step(1'b0, '0, '0, '0, 1'b1, a, e, e, 1'b0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, '0, '0, '0, 1'b0, '0, '0, '0, 1'b0);
   endtask

   // One reset cycle with a read and a write presented (both must be ignored).
   // Anything due on or after the reset edge is dropped.
   task automatic reset_pulse();
      int r_edge;
      r_edge = pcnt + 1;
      for (int d = 0; d < 3; d++) begin
         while (q[d].size() > 0 && q[d][q[d].size()-1].due >= r_edge) void'(q[d].pop_back());
      end
      rst           = 1'b1;
      tb_write      = 1'b1;
      tb_wr_address = 12'h040;
      tb_data_in    = 64'hBAD0_BAD0_BAD0_BAD0;
      tb_wr_byte_en = 8'hFF;
      tb_read       = 1'b1;
      tb_rd_address = 12'h040;
      $display("txn t=%0t reset with rd/wr @040 presented", $time);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         for (int d = 0; d < 3; d++) begin
            if (rst_s) begin
               check($sformatf("d%0d_rst_valid", d), {63'd0, vld[d]}, 64'd0);
               check($sformatf("d%0d_rst_data", d), dout[d], 64'd0);
               check($sformatf("d%0d_rst_col", d), {63'd0, coll[d]}, 64'd0);
               last_dout[d] = '0;
            end else begin
               logic exp_v;
               exp_v = (q[d].size() > 0) && (q[d][0].due == pcnt);
               check($sformatf("d%0d_valid", d), {63'd0, vld[d]}, {63'd0, exp_v});
               if (exp_v) begin
                  if (vld[d]) begin
                     check($sformatf("d%0d_data", d), dout[d], q[d][0].data);
                     check($sformatf("d%0d_col", d), {63'd0, coll[d]}, {63'd0, q[d][0].col});
                     last_dout[d] = q[d][0].data;
                  end
                  void'(q[d].pop_front());
               end else begin
                  check($sformatf("d%0d_hold", d), dout[d], last_dout[d]);
                  check($sformatf("d%0d_idle_col", d), {63'd0, coll[d]}, 64'd0);
               end
            end
         end
      end
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      mon_en = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;

      // basic write then read
      wr(12'h005, 64'hDEAD_BEEF_0123_4567, 8'hFF);
      rd(12'h005, 64'hDEAD_BEEF_0123_4567);

      // byte enables: low four lanes only
      wr(12'h010, 64'h1111_1111_1111_1111, 8'hFF);
      wr(12'h010, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F);
      rd(12'h010, 64'h1111_1111_FFFF_FFFF);

      // full collision: old vs merged data depending on policy
      wr(12'h020, 64'hAAAA_AAAA_AAAA_AAAA, 8'hFF);
      step(1'b1, 12'h020, 64'h5555_5555_5555_5555, 8'hFF, 1'b1, 12'h020,
           64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b1);
      rd(12'h020, 64'h5555_5555_5555_5555);
      // same address, byte_en=0: not a collision, no change
      step(1'b1, 12'h020, 64'h0, 8'h00, 1'b1, 12'h020,
           64'h5555_5555_5555_5555, 64'h5555_5555_5555_5555, 1'b0);
      // partial collision: only lane 0 replaced in write-first mode
      step(1'b1, 12'h020, 64'h0, 8'h01, 1'b1, 12'h020,
           64'h5555_5555_5555_5555, 64'h5555_5555_5555_5500, 1'b1);
      // different addresses in the same cycle are independent
      step(1'b1, 12'h030, 64'h3030_3030_3030_3030, 8'hFF, 1'b1, 12'h020,
           64'h5555_5555_5555_5500, 64'h5555_5555_5555_5500, 1'b0);
      rd(12'h030, 64'h3030_3030_3030_3030);

      // streaming: 8 back-to-back reads
      for (int i = 0; i < 8; i++) wr(12'h100 + 12'(i), 64'hC0FF_EE00_0000_0100 + 64'(i), 8'hFF);
      for (int i = 0; i < 8; i++) rd(12'h100 + 12'(i), 64'hC0FF_EE00_0000_0100 + 64'(i));
      // a write right after the accept must not alter the in-flight read
      rd(12'h105, 64'hC0FF_EE00_0000_0105);
      wr(12'h105, 64'h0505_0505_0505_0505, 8'hFF);
      rd(12'h105, 64'h0505_0505_0505_0505);
      idle(6);

      // reset with two reads in flight
      wr(12'h040, 64'h1234_5678_9ABC_DEF0, 8'hFF);
      rd(12'h040, 64'h1234_5678_9ABC_DEF0);
      rd(12'h040, 64'h1234_5678_9ABC_DEF0);
      reset_pulse();
      idle(3);
      rd(12'h040, 64'h1234_5678_9ABC_DEF0);
      rd(12'h005, 64'hDEAD_BEEF_0123_4567);

      // address boundaries
      wr(12'h000, 64'h0000_0000_0BAD_F00D, 8'hFF);
      wr(12'hFFF, 64'hFFFF_EEEE_DDDD_CCCC, 8'hFF);
      rd(12'h000, 64'h0000_0000_0BAD_F00D);
      rd(12'hFFF, 64'hFFFF_EEEE_DDDD_CCCC);

      idle(8);
      for (int d = 0; d < 3; d++) begin
         check($sformatf("d%0d_drain", d), 64'(q[d].size()), 64'd0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
